cache_miss_handler: RTL and testbench

Miss-service stage directly downstream of the direct-mapped cache controller. Accepts one read miss at a time, fetches the word from backing memory over a valid/ready request channel, then issues a one-cycle fill to the cache arrays (index `addr[5:0]`, tag `addr[31:6]`) and a response to the requester. Handles memory error responses and timeouts with bounded retry, and keeps a saturating miss counter for performance monitoring.

---
 rtl/cache_pkg.sv | 30 +++
 rtl/cache_miss_handler.sv | 122 ++++++++++++
 tb/tb_cache_miss_handler.sv | 398 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared types and address-split helpers for the
// direct-mapped cache and its miss handler.
package cache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_FILL,
    S_ERR
  } miss_state_t;

  localparam int ADDR_W     = 32;
  localparam int INDEX_W    = 6;
  localparam int TAG_W      = 26;
  localparam int MISS_CNT_W = 16;

  function automatic logic [INDEX_W-1:0] addr_index(
    input logic [ADDR_W-1:0] addr
  );
    return addr[INDEX_W-1:0];
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(
    input logic [ADDR_W-1:0] addr
  );
    return addr[ADDR_W-1:INDEX_W];
  endfunction

endpackage

// File: rtl/cache_miss_handler.sv
// Read-miss service stage: fetch from memory with
// bounded retry, then fill the cache and respond.
module cache_miss_handler
  import cache_pkg::*;
#(
  parameter int TIMEOUT   = 255,
  parameter int MAX_RETRY = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  miss_valid,
  input  logic [ADDR_W-1:0]     miss_addr,
  output logic                  miss_ready,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_W-1:0]     mem_req_addr,
  input  logic                  mem_resp_valid,
  input  logic [31:0]           mem_resp_data,
  input  logic                  mem_resp_error,
  output logic                  fill_valid,
  output logic [INDEX_W-1:0]    fill_index,
  output logic [TAG_W-1:0]      fill_tag,
  output logic [31:0]           fill_data,
  output logic                  resp_valid,
  output logic [31:0]           resp_data,
  output logic                  resp_error,
  output logic [MISS_CNT_W-1:0] miss_count
);

  localparam int TW = $clog2(TIMEOUT + 1);
  // A zero-retry build still needs a 1-bit counter.
  localparam int RW =
    (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRY);

  miss_state_t           state_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [31:0]           data_q;
  logic [TW-1:0]         timer_q;
  logic [RW-1:0]         retry_q;
  logic [MISS_CNT_W-1:0] miss_count_q;

  logic resp_ok;
  logic give_up;
  logic expired;

  // Classify the WAIT-cycle outcome; a response
  // beats a coincident timeout.
  always_comb begin
    resp_ok = mem_resp_valid && !mem_resp_error;
    expired = timer_q == T_LAST;
    give_up = !resp_ok && (mem_resp_valid || expired);
  end

  // Miss FSM plus the latched address, data,
  // timer, retry count and saturating miss count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      timer_q      <= '0;
      retry_q      <= '0;
      miss_count_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (miss_valid) begin
            addr_q  <= miss_addr;
            retry_q <= '0;
            timer_q <= '0;
            if (miss_count_q != '1)
              miss_count_q <= miss_count_q + 1'b1;
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            timer_q <= '0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          timer_q <= timer_q + 1'b1;
          if (resp_ok) begin
            data_q  <= mem_resp_data;
            state_q <= S_FILL;
          end else if (give_up) begin
            if (retry_q < R_MAX) begin
              retry_q <= retry_q + 1'b1;
              state_q <= S_REQ;
            end else begin
              state_q <= S_ERR;
            end
          end
        end
        S_FILL:  state_q <= S_IDLE;
        S_ERR:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Outputs decode from state and registers only.
  always_comb begin
    miss_ready    = state_q == S_IDLE;
    mem_req_valid = state_q == S_REQ;
    mem_req_addr  = addr_q;
    fill_valid    = state_q == S_FILL;
    fill_index    = addr_index(addr_q);
    fill_tag      = addr_tag(addr_q);
    fill_data     = data_q;
    resp_valid    = (state_q == S_FILL) ||
                    (state_q == S_ERR);
    resp_error    = state_q == S_ERR;
    resp_data     = (state_q == S_FILL) ? data_q : '0;
    miss_count    = miss_count_q;
  end

endmodule

// File: tb/tb_cache_miss_handler.sv
// Directed self-checking bench for the miss
// handler, built with TIMEOUT=8 and MAX_RETRY=2.
module tb_cache_miss_handler;

  logic        clock;
  logic        reset;
  logic        miss_valid;
  logic [31:0] miss_addr;
  logic        miss_ready;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        mem_resp_error;
  logic        fill_valid;
  logic [5:0]  fill_index;
  logic [25:0] fill_tag;
  logic [31:0] fill_data;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_error;
  logic [15:0] miss_count;

  int total = 0;
  int bad   = 0;

  cache_miss_handler #(
    .TIMEOUT   (8),
    .MAX_RETRY (2)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .miss_valid     (miss_valid),
    .miss_addr      (miss_addr),
    .miss_ready     (miss_ready),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .mem_resp_error (mem_resp_error),
    .fill_valid     (fill_valid),
    .fill_index     (fill_index),
    .fill_tag       (fill_tag),
    .fill_data      (fill_data),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .resp_error     (resp_error),
    .miss_count     (miss_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic test_reset();
    #2;
    total++;
    if ({miss_ready, mem_req_valid, fill_valid,
         resp_valid, resp_error} !== 5'b10000) begin
      bad++;
      $display("FAIL reset.flags got=%b exp=10000",
        {miss_ready, mem_req_valid, fill_valid,
         resp_valid, resp_error});
    end
    total++;
    if ({mem_req_addr, fill_index, fill_tag}
        !== 64'h0) begin
      bad++;
      $display("FAIL reset.addr got=%h/%h/%h exp=0",
        mem_req_addr, fill_index, fill_tag);
    end
    total++;
    if ({fill_data, resp_data, miss_count}
        !== 80'h0) begin
      bad++;
      $display("FAIL reset.data got=%h/%h/%h exp=0",
        fill_data, resp_data, miss_count);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    @(negedge clock);
    total++;
    if (miss_ready !== 1'b1) begin
      bad++;
      $display("FAIL basic.ready got=%b exp=1",
        miss_ready);
    end
    miss_valid    = 1'b1;
    miss_addr     = 32'h0000_1044;
    mem_req_ready = 1'b1;
    @(negedge clock);
    miss_valid = 1'b0;
    total++;
    if ({miss_ready, mem_req_valid} !== 2'b01 ||
        mem_req_addr !== 32'h0000_1044) begin
      bad++;
      $display("FAIL basic.req got=%b/%h exp=01/1044",
        {miss_ready, mem_req_valid}, mem_req_addr);
    end
    @(negedge clock);
    total++;
    if ({mem_req_valid, resp_valid} !== 2'b00) begin
      bad++;
      $display("FAIL basic.wait got=%b exp=00",
        {mem_req_valid, resp_valid});
    end
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hDEAD_BEEF;
    @(negedge clock);
    mem_resp_valid = 1'b0;
    total++;
    if ({fill_valid, resp_valid, resp_error}
        !== 3'b110) begin
      bad++;
      $display("FAIL basic.pulse got=%b exp=110",
        {fill_valid, resp_valid, resp_error});
    end
    total++;
    if (fill_index !== 6'h04 ||
        fill_tag !== 26'h41) begin
      bad++;
      $display("FAIL basic.split got=%h/%h exp=04/41",
        fill_index, fill_tag);
    end
    total++;
    if (fill_data !== 32'hDEAD_BEEF ||
        resp_data !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL basic.data got=%h/%h exp=deadbeef",
        fill_data, resp_data);
    end
    total++;
    if (miss_count !== 16'd1) begin
      bad++;
      $display("FAIL basic.count got=%0d exp=1",
        miss_count);
    end
    @(negedge clock);
    total++;
    if ({miss_ready, fill_valid, resp_valid}
        !== 3'b100) begin
      bad++;
      $display("FAIL basic.idle got=%b exp=100",
        {miss_ready, fill_valid, resp_valid});
    end
  endtask

  task automatic test_req_stall();
    mem_req_ready = 1'b0;
    miss_valid    = 1'b1;
    miss_addr     = 32'h2000_00C7;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      miss_valid = 1'b0;
      total++;
      if (mem_req_valid !== 1'b1 || resp_valid !== 1'b0
          || mem_req_addr !== 32'h2000_00C7) begin
        bad++;
        $display("FAIL stall.hold%0d got=%b/%b/%h exp=1/0/200000c7",
          i, mem_req_valid, resp_valid, mem_req_addr);
      end
    end
    mem_req_ready = 1'b1;
    @(negedge clock);
    total++;
    if (mem_req_valid !== 1'b0) begin
      bad++;
      $display("FAIL stall.wait got=%b exp=0",
        mem_req_valid);
    end
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hCAFE_0001;
    @(negedge clock);
    mem_resp_valid = 1'b0;
    total++;
    if ({fill_valid, resp_error} !== 2'b10 ||
        fill_data !== 32'hCAFE_0001) begin
      bad++;
      $display("FAIL stall.fill got=%b/%h exp=10/cafe0001",
        {fill_valid, resp_error}, fill_data);
    end
    total++;
    if (fill_index !== 6'h07 ||
        fill_tag !== 26'h080_0003 ||
        miss_count !== 16'd2) begin
      bad++;
      $display("FAIL stall.split got=%h/%h/%0d exp=07/0800003/2",
        fill_index, fill_tag, miss_count);
    end
    @(negedge clock);
  endtask

  task automatic test_error_retry();
    int  hs   = 0;
    int  last = 0;
    bit  pend = 0;
    bit  done = 0;
    mem_req_ready = 1'b1;
    miss_valid    = 1'b1;
    miss_addr     = 32'h0000_0ABC;
    for (int k = 1; k <= 40 && !done; k++) begin
      @(negedge clock);
      miss_valid     = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_error = 1'b0;
      if (pend) begin
        mem_resp_valid = 1'b1;
        mem_resp_error = hs < 3;
        mem_resp_data  = (hs < 3) ? 32'hBAD0_0000
                                  : 32'h1234_5678;
        pend = 0;
      end
      if (mem_req_valid) begin
        hs++;
        pend = 1;
      end
      if (resp_valid) begin
        done = 1;
        last = k;
        total++;
        if (hs != 3 || last != 7) begin
          bad++;
          $display("FAIL retry.count got=%0d/%0d exp=3/7",
            hs, last);
        end
        total++;
        if ({fill_valid, resp_error} !== 2'b10 ||
            resp_data !== 32'h1234_5678 ||
            fill_data !== 32'h1234_5678) begin
          bad++;
          $display("FAIL retry.fill got=%b/%h/%h exp=10/12345678",
            {fill_valid, resp_error}, resp_data, fill_data);
        end
      end
    end
    mem_resp_valid = 1'b0;
    mem_resp_error = 1'b0;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL retry.done got=0 exp=1");
    end
    @(negedge clock);
  endtask

  task automatic test_timeout();
    int hs   = 0;
    int last = 0;
    int r1   = 0;
    int r2   = 0;
    int r3   = 0;
    bit done = 0;
    mem_req_ready = 1'b1;
    miss_valid    = 1'b1;
    miss_addr     = 32'h0000_0100;
    for (int k = 1; k <= 60 && !done; k++) begin
      @(negedge clock);
      miss_valid = 1'b0;
      if (mem_req_valid) begin
        hs++;
        if (hs == 1) r1 = k;
        if (hs == 2) r2 = k;
        if (hs == 3) r3 = k;
      end
      if (resp_valid) begin
        done = 1;
        last = k;
        total++;
        if ({fill_valid, resp_error} !== 2'b01 ||
            resp_data !== 32'h0) begin
          bad++;
          $display("FAIL tmo.err got=%b/%h exp=01/0",
            {fill_valid, resp_error}, resp_data);
        end
      end
    end
    total++;
    if (!done || hs != 3 || last != 28) begin
      bad++;
      $display("FAIL tmo.timing got=%0d/%0d/%0d exp=1/3/28",
        done, hs, last);
    end
    total++;
    if (r1 != 1 || r2 != 10 || r3 != 19) begin
      bad++;
      $display("FAIL tmo.reqs got=%0d,%0d,%0d exp=1,10,19",
        r1, r2, r3);
    end
    @(negedge clock);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h5555_5555;
    @(negedge clock);
    mem_resp_valid = 1'b0;
    total++;
    if ({miss_ready, fill_valid, resp_valid}
        !== 3'b100 || miss_count !== 16'd4) begin
      bad++;
      $display("FAIL tmo.late got=%b/%0d exp=100/4",
        {miss_ready, fill_valid, resp_valid}, miss_count);
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    mem_req_ready = 1'b1;
    miss_valid    = 1'b1;
    miss_addr     = 32'h3000_0040;
    @(negedge clock);
    miss_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    total++;
    if ({miss_ready, mem_req_valid} !== 2'b10 ||
        miss_count !== 16'd0 ||
        mem_req_addr !== 32'h0) begin
      bad++;
      $display("FAIL rstmid.now got=%b/%0d/%h exp=10/0/0",
        {miss_ready, mem_req_valid}, miss_count,
        mem_req_addr);
    end
    @(negedge clock);
    reset          = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h0000_0077;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      mem_resp_valid = 1'b0;
      if (resp_valid || fill_valid || !miss_ready)
        seen = 1;
    end
    total++;
    if (seen || miss_count !== 16'd0) begin
      bad++;
      $display("FAIL rstmid.drop got=%b/%0d exp=0/0",
        seen, miss_count);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clock);
    dut.miss_count_q = 16'hFFFE;
    mem_req_ready = 1'b1;
    for (int n = 0; n < 2; n++) begin
      total++;
      if (miss_ready !== 1'b1) begin
        bad++;
        $display("FAIL b2b.ready%0d got=%b exp=1",
          n, miss_ready);
      end
      miss_valid = 1'b1;
      miss_addr  = 32'h0000_0200 + 32'(n);
      @(negedge clock);
      miss_valid = 1'b0;
      @(negedge clock);
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'hA0A0_0000 + 32'(n);
      @(negedge clock);
      mem_resp_valid = 1'b0;
      total++;
      if (fill_valid !== 1'b1 ||
          miss_count !== 16'hFFFF) begin
        bad++;
        $display("FAIL b2b.sat%0d got=%b/%h exp=1/ffff",
          n, fill_valid, miss_count);
      end
      @(negedge clock);
    end
  endtask

  initial begin
    reset          = 1'b1;
    miss_valid     = 1'b0;
    miss_addr      = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    mem_resp_error = 1'b0;
    test_reset();
    test_basic();
    test_req_stall();
    test_error_retry();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d",
      total, bad);
    $finish;
  end

endmodule
